// File: rtl/wb_port_arb_pkg.sv
// Shared definitions for the writeback port arbiter: bus field layout
// {data, addr, regw} and pack/unpack helpers for the default widths.
package wb_port_arb_pkg;

  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF     = 32;

  // Field offsets inside a packed writeback bus entry
  localparam int REGW_BIT = 0;
  localparam int ADDR_LSB = 1;

  function automatic int data_lsb(input int aw);
    return 1 + aw;
  endfunction

  function automatic int bus_width(input int aw, input int dw);
    return dw + aw + 1;
  endfunction

  localparam int BUS_W_DEF = bus_width(REG_ADDR_WIDTH_DEF, DATA_WIDTH_DEF);

  // Field view of one entry at the default widths; layout matches the packed bus
  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0]     data;
    logic [REG_ADDR_WIDTH_DEF-1:0] addr;
    logic                          regw;
  } wb_entry_t;

  function automatic logic [BUS_W_DEF-1:0] pack_entry(
    input logic [DATA_WIDTH_DEF-1:0]     data,
    input logic [REG_ADDR_WIDTH_DEF-1:0] addr,
    input logic                          regw
  );
    wb_entry_t e;
    e.data = data;
    e.addr = addr;
    e.regw = regw;
    return e;
  endfunction

  function automatic wb_entry_t unpack_entry(input logic [BUS_W_DEF-1:0] bus);
    return wb_entry_t'(bus);
  endfunction

endpackage

// File: rtl/wb_port_arb_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo N. Produces a one-hot grant, its index and an any flag.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan ptr, ptr+1, ... and stop at the first requester found
  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_port_arb.sv
// Writeback port arbiter: shares the single register-file write port among
// NUM_REQ producers with round-robin priority and one registered output stage.
//
// Handshake: a beat moves on any cycle where valid and ready are both high at
// the rising clock edge. Producers hold valid and bus stable until accepted;
// ready never depends on the producer's own bus contents, and the output entry
// stays stable while out_valid is high and out_ready is low.
module wb_port_arb
  import wb_port_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 2,
  parameter  int REG_ADDR_WIDTH = 5,
  parameter  int DATA_WIDTH     = 32,
  localparam int BUS_W          = bus_width(REG_ADDR_WIDTH, DATA_WIDTH),
  localparam int IW             = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*BUS_W-1:0] req_bus,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BUS_W-1:0]         out_bus,
  output logic [IW-1:0]            out_src,
  output logic                     wb_done
);

  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;
  logic               can_load;
  logic               xfer;
  logic [BUS_W-1:0]   bus_arr [NUM_REQ];
  logic [BUS_W-1:0]   sel_bus;

  // Unpack the flat requester bus into one entry per requester
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign bus_arr[i] = req_bus[i*BUS_W +: BUS_W];
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // The output register may refill in the same cycle its entry is consumed;
  // nothing is accepted while reset is asserted.
  assign can_load  = (~out_valid | out_ready) & ~rst;
  assign req_ready = grant & {NUM_REQ{can_load}};
  assign xfer      = grant_any & can_load;
  assign wb_done   = out_valid;

  // Select the winner's entry and suppress writes aimed at register x0
  always_comb begin
    sel_bus = bus_arr[grant_idx];
    if (sel_bus[REGW_BIT] && (sel_bus[ADDR_LSB +: REG_ADDR_WIDTH] == '0)) begin
      sel_bus[REGW_BIT] = 1'b0;
    end
  end

  // Output stage and round-robin pointer; pointer only advances on a transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bus   <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_bus   <= sel_bus;
      out_src   <= grant_idx;
      rr_ptr    <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arb.sv
// Self-checking bench for wb_port_arb (2 requesters, default widths).
module tb_wb_port_arb;
  import wb_port_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int AW      = REG_ADDR_WIDTH_DEF;
  localparam int DW      = DATA_WIDTH_DEF;
  localparam int BUS_W   = BUS_W_DEF;
  localparam int IW      = 1;
  localparam int EW      = IW + BUS_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*BUS_W-1:0] req_bus   = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [BUS_W-1:0]         out_bus;
  logic [IW-1:0]            out_src;
  logic                     wb_done;

  int checks = 0;
  int errors = 0;

  wb_port_arb #(
    .NUM_REQ(NUM_REQ), .REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_bus(req_bus),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bus(out_bus), .out_src(out_src), .wb_done(wb_done)
  );

  // ---------------- reference model helpers ----------------
  function automatic logic [BUS_W-1:0] guard(input logic [BUS_W-1:0] b);
    wb_entry_t e;
    e = unpack_entry(b);
    if (e.regw && e.addr == '0) e.regw = 1'b0;
    return e;
  endfunction

  function automatic logic [BUS_W-1:0] rand_bus();
    return pack_entry($urandom, AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    exp_e;
  logic             prev_hold = 1'b0;
  logic [BUS_W-1:0] prev_bus;
  logic [IW-1:0]    prev_src;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      checks++;
      if (wb_done !== out_valid) begin
        errors++;
        $display("FAIL wb_done got=%b want=%b", wb_done, out_valid);
      end
      checks++;
      if ((req_ready & (req_ready - 1'b1)) != '0 || (req_ready & ~req_valid) != '0) begin
        errors++;
        $display("FAIL ready_onehot got=%b valid=%b", req_ready, req_valid);
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow got src=%0d bus=%h want none", out_src, out_bus);
        end else begin
          exp_e = exp_q.pop_front();
          if ({out_src, out_bus} !== exp_e) begin
            errors++;
            $display("FAIL sb_entry got=%h want=%h", {out_src, out_bus}, exp_e);
          end
        end
      end
      if (prev_hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_bus !== prev_bus || out_src !== prev_src) begin
          errors++;
          $display("FAIL hold_stable got v=%b src=%0d bus=%h want v=1 src=%0d bus=%h",
                   out_valid, out_src, out_bus, prev_src, prev_bus);
        end
      end
      if (out_valid === 1'b1 && !out_ready) begin
        checks++;
        if (req_ready !== '0) begin
          errors++;
          $display("FAIL hold_ready got=%b want=00", req_ready);
        end
      end
      prev_hold = (out_valid === 1'b1) && !out_ready;
      prev_bus  = out_bus;
      prev_src  = out_src;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req_valid[j] && req_ready[j])
          exp_q.push_back({IW'(j), guard(req_bus[j*BUS_W +: BUS_W])});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_bus(input int j, input logic [BUS_W-1:0] b);
    req_bus[j*BUS_W +: BUS_W] = b;
  endtask

  task automatic drain();
    req_valid = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d pending want=0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    req_valid = 2'b11;
    set_bus(0, rand_bus());
    set_bus(1, rand_bus());
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_src !== '0 || out_bus !== '0) begin
        errors++;
        $display("FAIL reset_out got v=%b src=%0d bus=%h want 0", out_valid, out_src, out_bus);
      end
      checks++;
      if (req_ready !== 2'b00) begin
        errors++;
        $display("FAIL reset_ready got=%b want=00", req_ready);
      end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_grant got=%b want=01", req_ready);
    end
    drain();
  endtask

  task automatic test_contention();
    logic [1:0] acc;
    do_reset();
    out_ready = 1'b1;
    set_bus(0, rand_bus());
    set_bus(1, rand_bus());
    req_valid = 2'b11;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== (2'b01 << (c % 2))) begin
        errors++;
        $display("FAIL cont_grant c=%0d got=%b want=%b", c, req_ready, 2'b01 << (c % 2));
      end
      if (c > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_src !== IW'((c - 1) % 2)) begin
          errors++;
          $display("FAIL cont_src c=%0d got v=%b src=%0d want v=1 src=%0d",
                   c, out_valid, out_src, (c - 1) % 2);
        end
      end
      acc = req_valid & req_ready;
      tick();
      for (int j = 0; j < NUM_REQ; j++) if (acc[j]) set_bus(j, rand_bus());
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [BUS_W-1:0] held;
    logic [BUS_W-1:0] nxt;
    do_reset();
    out_ready = 1'b0;
    held = pack_entry(32'hDEADBEEF, 5'd5, 1'b1);
    nxt  = pack_entry(32'hCAFEF00D, 5'd9, 1'b1);
    set_bus(0, held);
    set_bus(1, nxt);
    req_valid = 2'b11;
    tick();
    req_valid = 2'b10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_bus !== held || out_src !== 1'b0 || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold c=%0d got v=%b src=%0d bus=%h rdy=%b want v=1 src=0 bus=%h rdy=00",
                 c, out_valid, out_src, out_bus, req_ready, held);
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_release_ready got=%b want=10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b1 || out_bus !== nxt) begin
      errors++;
      $display("FAIL bp_no_bubble got v=%b src=%0d bus=%h want v=1 src=1 bus=%h",
               out_valid, out_src, out_bus, nxt);
    end
    drain();
  endtask

  task automatic test_x0_guard();
    do_reset();
    out_ready = 1'b1;
    set_bus(1, pack_entry(32'h12345678, 5'd0, 1'b1));
    req_valid = 2'b10;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL x0_grant got=%b want=10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_bus !== pack_entry(32'h12345678, 5'd0, 1'b0)) begin
      errors++;
      $display("FAIL x0_guard got v=%b bus=%h want v=1 bus=%h",
               out_valid, out_bus, pack_entry(32'h12345678, 5'd0, 1'b0));
    end
    drain();
  endtask

  task automatic test_idle_ptr();
    do_reset();
    out_ready = 1'b1;
    set_bus(1, rand_bus());
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b00) begin
        errors++;
        $display("FAIL idle_ready c=%0d got=%b want=00", c, req_ready);
      end
      tick();
    end
    set_bus(0, rand_bus());
    set_bus(1, rand_bus());
    req_valid = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL idle_ptr got=%b want=01", req_ready);
    end
    drain();
  endtask

  task automatic test_reset_midop();
    do_reset();
    out_ready = 1'b0;
    set_bus(0, rand_bus());
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midop_loaded got=%b want=1", out_valid);
    end
    tick();
    rst = 1'b1;
    set_bus(1, rand_bus());
    req_valid = 2'b10;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL midop_rst_ready got=%b want=00", req_ready);
    end
    tick();
    rst = 1'b0;
    set_bus(0, rand_bus());
    req_valid = 2'b11;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 2'b01) begin
      errors++;
      $display("FAIL midop_after got v=%b rdy=%b want v=0 rdy=01", out_valid, req_ready);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [1:0] acc;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      out_ready = 1'($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
      for (int j = 0; j < NUM_REQ; j++) begin
        if (acc[j] || !req_valid[j]) begin
          req_valid[j] = 1'($urandom_range(0, 1));
          set_bus(j, rand_bus());
        end
      end
    end
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_contention();
    test_backpressure();
    test_x0_guard();
    test_idle_ptr();
    test_reset_midop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
